gdp_summation: RTL and testbench
================================

GDP_SUMMATION -- requirements
Module: GDP

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of n_in, runSum and the internal registers.
REQ-002 Port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port restart, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: level request to begin a computation; sampled only in IDLE.
REQ-005 Port n_in, input, WIDTH bits: unsigned operand n; captured when start is accepted.
REQ-006 Port runSum, output, WIDTH bits: running/final value of sum(1..n), driven directly from the sum register.
REQ-007 Port done, output, 1 bit: high while the final result is valid; Moore output of the DONE state.

Function
REQ-008 The block SHALL consist of a control FSM (IDLE, LOAD, TEST, ADD, DONE) and a datapath with registers nreg, cnt and sum, all WIDTH bits.
REQ-009 IDLE: if start=1 at a rising edge, nreg <= n_in and the next state is LOAD; otherwise the block stays in IDLE.
REQ-010 LOAD: sum <= 0, cnt <= nreg, next state TEST.
REQ-011 TEST: if cnt==0, next state DONE; otherwise next state ADD; no register changes.
REQ-012 ADD: sum <= sum+cnt, cnt <= cnt-1, next state TEST.
REQ-013 DONE: done=1 and runSum holds the result; the block SHALL remain in DONE, ignoring start and n_in, until restart.
REQ-014 done SHALL be 0 in every state other than DONE.
REQ-015 Latency: done SHALL rise exactly 2n+2 rising edges after the edge that accepts start (n=0 gives 2; n=5 gives 12).
REQ-016 runSum SHALL show intermediate partial sums during computation; only the value present while done=1 is defined as the result.
REQ-017 Arithmetic SHALL be unsigned; without the macro in REQ-024, addition wraps modulo 2^WIDTH (n=23 gives 20).
REQ-018 A change on n_in after start is accepted SHALL NOT affect the computation in progress.
REQ-019 If start and restart are both high, restart SHALL dominate; start is only acted on after restart is low at a rising edge.

Reset
REQ-020 restart=1 SHALL immediately, without waiting for a clock edge, force the state to IDLE and nreg, cnt, sum, runSum and done to 0.
REQ-021 While restart=1, the block SHALL hold all reset values regardless of clock and start.
REQ-022 restart asserted mid-computation (LOAD, TEST or ADD) SHALL abort it, with no residual state.
REQ-023 After restart is released, the first rising edge with start=1 SHALL be accepted as a new request.

Configuration
REQ-024 Macro GDP_SATURATE_EN SHALL be the only compile-time option.
REQ-025 When GDP_SATURATE_EN is defined, sum+cnt exceeding 2^WIDTH-1 SHALL clamp sum to 2^WIDTH-1 (n=23 gives 255), and sum SHALL stay clamped for the remaining iterations.
REQ-026 When GDP_SATURATE_EN is undefined, wrap-around per REQ-017 SHALL apply; latency and ports SHALL be identical in both builds.

Verification
REQ-027 Sweep: for n=0..22, restart pulse, then start=1 -> done=1 with runSum=n(n+1)/2 (0, 1, 3, ... 253), each with latency 2n+2.
REQ-028 Boundary: n=0, start -> done after 2 edges, runSum=0; n=22 -> runSum=253 after 46 edges.
REQ-029 Overflow: n=23 -> runSum=20 (macro off) or 255 (GDP_SATURATE_EN on); n=255 -> runSum=128 (off) or 255 (on).
REQ-030 Abort: n=10, start, assert restart 5 edges later, asynchronously between edges -> done=0 and runSum=0 immediately, state IDLE; then n=4, start -> runSum=10.
REQ-031 Hold/priority: in DONE with n=5, toggle start and change n_in to 9 -> runSum stays 15 and done stays 1; restart and start both high for 1 cycle -> no computation until restart is low.

Source files
------------

// File: rtl/gdp_summation.sv
`default_nettype none
// ============================================================================
//  Module      : gdp_summation
//  Description : Iterative sum(1..n) engine. A five-state control FSM
//                (IDLE, LOAD, TEST, ADD, DONE) sequences a datapath of three
//                WIDTH-bit registers (nreg, cnt, sum). One addition is done
//                per TEST/ADD pair, so a result is ready 2n+2 edges after
//                start is accepted. The block parks in DONE until restart.
//                Compile-time option GDP_SATURATE_EN: clamp sum at
//                2^WIDTH-1 instead of wrapping modulo 2^WIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module gdp_summation #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             restart,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic [WIDTH-1:0] runSum,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        TEST = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] nreg;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sum_next;

`ifdef GDP_SATURATE_EN
    logic [WIDTH:0]   sum_wide;

    // Widened add; a carry out means the true sum no longer fits, so clamp.
    // Once clamped, every later add carries too, keeping sum at the ceiling.
    always_comb begin
        sum_wide = {1'b0, sum} + {1'b0, cnt};
        sum_next = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
    end
`else
    // Plain modulo-2^WIDTH accumulation.
    always_comb begin
        sum_next = sum + cnt;
    end
`endif

    // State register; restart forces IDLE without waiting for an edge.
    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; DONE is terminal until restart.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? LOAD : IDLE;
            LOAD:    state_next = TEST;
            TEST:    state_next = (cnt == '0) ? DONE : ADD;
            ADD:     state_next = TEST;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers, updated according to the current control state.
    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            nreg <= '0;
            cnt  <= '0;
            sum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nreg <= n_in;
                    end
                end
                LOAD: begin
                    sum <= '0;
                    cnt <= nreg;
                end
                ADD: begin
                    sum <= sum_next;
                    cnt <= cnt - ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign runSum = sum;
    assign done   = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_gdp_summation.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gdp_summation
//  Description : Directed self-checking bench for gdp_summation (WIDTH=8).
//                Expected overflow results follow GDP_SATURATE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gdp_summation;

    logic       clock;
    logic       restart;
    logic       start;
    logic [7:0] n_in;
    logic [7:0] runSum;
    logic       done;

    int tests_run;
    int tests_failed;

    gdp_summation #(.WIDTH(8)) dut (
        .clock   (clock),
        .restart (restart),
        .start   (start),
        .n_in    (n_in),
        .runSum  (runSum),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue a start with operand n at a negedge, then count rising edges
    // after the accepting edge until done is seen (-1 on timeout).
    task automatic run_calc(input logic [7:0] n, output int edges, output logic [7:0] res);
        @(negedge clock);
        n_in  = n;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        edges = -1;
        for (int i = 1; i <= 600; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                edges = i;
                break;
            end
        end
        res = runSum;
    endtask

    task automatic pulse_restart();
        @(negedge clock);
        restart = 1'b1;
        #2;
        restart = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        restart = 1'b1;
        #1;
        tests_run++;
        if (runSum !== 8'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: runSum=%0d done=%b, required runSum=0 done=0", runSum, done);
        end
        start = 1'b1;
        n_in  = 8'd7;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (runSum !== 8'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: runSum=%0d done=%b, required runSum=0 done=0", runSum, done);
        end
        @(negedge clock);
        start   = 1'b0;
        restart = 1'b0;
    endtask

    task automatic test_sweep();
        int         edges;
        logic [7:0] res;
        int         exp_sum;
        for (int n = 0; n <= 22; n++) begin
            pulse_restart();
            run_calc(n[7:0], edges, res);
            exp_sum = n * (n + 1) / 2;
            tests_run++;
            if (res !== exp_sum[7:0]) begin
                tests_failed++;
                $display("FAIL sweep_sum n=%0d: runSum=%0d, required %0d", n, res, exp_sum);
            end
            tests_run++;
            if (edges != 2 * n + 2) begin
                tests_failed++;
                $display("FAIL sweep_latency n=%0d: edges=%0d, required %0d", n, edges, 2 * n + 2);
            end
        end
    endtask

    task automatic test_boundary();
        int         edges;
        logic [7:0] res;
        pulse_restart();
        run_calc(8'd0, edges, res);
        tests_run++;
        if (res !== 8'd0 || edges != 2) begin
            tests_failed++;
            $display("FAIL boundary_n0: runSum=%0d edges=%0d, required 0 and 2", res, edges);
        end
        pulse_restart();
        run_calc(8'd22, edges, res);
        tests_run++;
        if (res !== 8'd253 || edges != 46) begin
            tests_failed++;
            $display("FAIL boundary_n22: runSum=%0d edges=%0d, required 253 and 46", res, edges);
        end
    endtask

    task automatic test_overflow();
        int         edges;
        logic [7:0] res;
        logic [7:0] exp23;
        logic [7:0] exp255;
`ifdef GDP_SATURATE_EN
        exp23  = 8'd255;
        exp255 = 8'd255;
`else
        exp23  = 8'd20;
        exp255 = 8'd128;
`endif
        pulse_restart();
        run_calc(8'd23, edges, res);
        tests_run++;
        if (res !== exp23 || edges != 48) begin
            tests_failed++;
            $display("FAIL overflow_n23: runSum=%0d edges=%0d, required %0d and 48", res, edges, exp23);
        end
        pulse_restart();
        run_calc(8'd255, edges, res);
        tests_run++;
        if (res !== exp255 || edges != 512) begin
            tests_failed++;
            $display("FAIL overflow_n255: runSum=%0d edges=%0d, required %0d and 512", res, edges, exp255);
        end
    endtask

    task automatic test_abort();
        int         edges;
        logic [7:0] res;
        pulse_restart();
        @(negedge clock);
        n_in  = 8'd10;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_in  = 8'd99;
        // Edges: LOAD, TEST, ADD(+10), TEST, ADD(+9) -> partial sum 19
        repeat (5) @(posedge clock);
        #3;
        tests_run++;
        if (runSum !== 8'd19 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_partial: runSum=%0d done=%b, required 19 and 0", runSum, done);
        end
        restart = 1'b1;
        #1;
        tests_run++;
        if (runSum !== 8'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_immediate: runSum=%0d done=%b, required 0 and 0", runSum, done);
        end
        @(negedge clock);
        restart = 1'b0;
        run_calc(8'd4, edges, res);
        tests_run++;
        if (res !== 8'd10 || edges != 10) begin
            tests_failed++;
            $display("FAIL abort_recover: runSum=%0d edges=%0d, required 10 and 10", res, edges);
        end
    endtask

    task automatic test_hold_priority();
        int         edges;
        logic [7:0] res;
        pulse_restart();
        run_calc(8'd5, edges, res);
        tests_run++;
        if (res !== 8'd15 || edges != 12) begin
            tests_failed++;
            $display("FAIL hold_setup: runSum=%0d edges=%0d, required 15 and 12", res, edges);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            start = ~start;
            n_in  = 8'd9;
            @(negedge clock);
            tests_run++;
            if (runSum !== 8'd15 || done !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold_done k=%0d: runSum=%0d done=%b, required 15 and 1", k, runSum, done);
            end
        end
        @(negedge clock);
        restart = 1'b1;
        start   = 1'b1;
        n_in    = 8'd3;
        #1;
        tests_run++;
        if (runSum !== 8'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL priority_reset: runSum=%0d done=%b, required 0 and 0", runSum, done);
        end
        @(negedge clock);
        restart = 1'b0;
        start   = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        tests_run++;
        if (runSum !== 8'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL priority_idle: runSum=%0d done=%b, required 0 and 0", runSum, done);
        end
        run_calc(8'd3, edges, res);
        tests_run++;
        if (res !== 8'd6 || edges != 8) begin
            tests_failed++;
            $display("FAIL priority_restart_ok: runSum=%0d edges=%0d, required 6 and 8", res, edges);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        restart      = 1'b0;
        start        = 1'b0;
        n_in         = 8'd0;
        test_reset();
        test_sweep();
        test_boundary();
        test_overflow();
        test_abort();
        test_hold_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
